// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory path: responder FSM states,
// byte/counter widths and the address legality check used on both sides
// of the load/store port.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DATA_BYTES     = 4;
    localparam int WAIT_CNT_WIDTH = 4;

    // A byte address is bad when it is not word aligned or when any bit
    // above the word-index field is set (the word lies beyond the RAM).
    function automatic logic addr_is_bad(input logic [31:0] addr,
                                         input int unsigned addr_width);
        logic [31:0] upper;
        upper = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/mem_sram.sv
// Single-port synchronous RAM with a registered read port and per-byte
// write enables. The read is read-first: rd shows the old word on a write.
module mem_sram
    import mem_pkg::*;
#(
    parameter int WORDS      = 512,
    parameter int ADDR_WIDTH = $clog2(WORDS),
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_BYTES-1:0] be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Byte-masked write and registered read of the addressed word.
    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a huge register file and its contents must survive reset anyway.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wd[8*i +: 8];
            end
        end
        rd <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Accepts one load/store at a
// time, waits WAIT_CYCLES clocks, performs the RAM access, then holds the
// response until the initiator takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int WORDS       = 512,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WIDTH  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_BYTES-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

    mem_state_t                state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

    // Request fields captured at the accept edge.
    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_BYTES-1:0] lat_wstrb;

    // Fields of the request being accessed this cycle.
    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [DATA_BYTES-1:0] cur_wstrb;
    logic                  cur_err;

    logic                  accept;
    logic                  access_now;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rd;

    assign accept     = (state == IDLE) && req_ready && req_valid;
    assign access_now = (accept && NO_WAIT) || ((state == WAIT) && (wait_cnt == '0));

    // Select the live request in IDLE (zero-wait access happens on the
    // accept edge, before the latches load) and the latched one otherwise.
    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_wstrb = lat_wstrb;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_wstrb = req_wstrb;
        end
    end

    assign cur_err = addr_is_bad(cur_addr, ADDR_WIDTH);

    // A write on an edge where reset is also asserted is dropped with the
    // rest of the transaction.
    assign ram_we = access_now && cur_we && !cur_err && !reset;

    mem_sram #(
        .WORDS      (WORDS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .clk  (clk),
        .we   (ram_we),
        .be   (cur_wstrb),
        .addr (cur_addr[ADDR_WIDTH+1:2]),
        .wd   (cur_wdata),
        .rd   (ram_rd)
    );

    // Capture the request on the accept edge.
    // NOTE: datapath latches carry no reset; they are only read after an
    // accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    // Control FSM with registered handshake outputs and error flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= cur_err;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cur_err;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Read data comes straight from the RAM output register, which stays
    // stable through RESP because the RAM address is held by the latches.
    assign rsp_rdata = (rsp_valid && !lat_we && !rsp_err) ? ram_rd : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with WAIT_CYCLES 0, 1 and 3
// share clock and reset; a word-array model supplies expected responses.
module tb_data_mem_responder;

    localparam int ND = 3;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [ND];
    logic        req_ready [ND];
    logic        req_we    [ND];
    logic [31:0] req_addr  [ND];
    logic [31:0] req_wdata [ND];
    logic [3:0]  req_wstrb [ND];
    logic        rsp_valid [ND];
    logic        rsp_ready [ND];
    logic [31:0] rsp_rdata [ND];
    logic        rsp_err   [ND];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] mdl [ND][512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    data_mem_responder #(.WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: byte-addressed 2 KiB store, word granular.
    function automatic void model_txn(input int d, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wstrb,
                                      output logic [31:0] rdata, output logic err);
        int w;
        err   = (addr % 4 != 0) || (addr >= 32'd2048);
        rdata = 32'd0;
        if (!err) begin
            w = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mdl[d][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata = mdl[d][w];
            end
        end
    endfunction

    // Issue one request with rsp_ready high; returns at the falling edge
    // where the response is first visible.
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int acc);
        int n;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_wstrb[d] = wstrb;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < TMO) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
    endtask

    task automatic txn_check(input int d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, acc;
        model_txn(d, we, addr, wdata, wstrb, erd, eer);
        do_txn(d, we, addr, wdata, wstrb, rd, er, lat, acc);
        check($sformatf("d%0d %s %h rdata", d, we ? "wr" : "rd", addr), rd, erd);
        check($sformatf("d%0d %s %h err", d, we ? "wr" : "rd", addr), 32'(er), 32'(eer));
        check($sformatf("d%0d %s %h latency", d, we ? "wr" : "rd", addr), lat, wc(d) + 1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, acc, acc2;
        int          bad;
        logic [31:0] a, exp_hold;

        reset = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_wstrb[d] = '0; rsp_ready[d] = 1'b1;
        end

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd0);
            check($sformatf("d%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
        end
        check("reset rsp_rdata", rsp_rdata[1], 32'd0);
        check("reset rsp_err", 32'(rsp_err[1]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            check($sformatf("d%0d req_ready after reset", d), 32'(req_ready[d]), 32'd1);

        // ---- directed table on WAIT_CYCLES=1 ----
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_0011, 4'h1, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BE11, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0800, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hA, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hCAA5_F0A5, 1'b0};
        vecs[13] = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 32'h0000_07FC, 32'h0BAD_CAFE, 4'hF, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 32'h0000_07FC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0803, 32'h0,         4'h0, 32'h0,         1'b1};

        for (int i = 0; i < 17; i++) begin
            model_txn(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, mrd, mer);
            do_txn(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat, acc);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), lat, 2);
        end

        // ---- backpressure: hold rsp_ready low for 5 cycles ----
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        req_we[1] = 1'b0; req_addr[1] = 32'h10; req_valid[1] = 1'b1;
        bad = 0;
        while (!req_ready[1] && bad < TMO) begin @(negedge clk); bad++; end
        @(negedge clk);
        req_valid[1] = 1'b0;
        bad = 0;
        while (!rsp_valid[1] && bad < TMO) begin @(negedge clk); bad++; end
        check("bp response arrives", 32'(rsp_valid[1]), 32'd1);
        exp_hold = mdl[1][4];
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid[1]), 32'd1);
            check($sformatf("bp%0d rsp_rdata", k), rsp_rdata[1], exp_hold);
            check($sformatf("bp%0d rsp_err", k), 32'(rsp_err[1]), 32'd0);
            check($sformatf("bp%0d req_ready", k), 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp release rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("bp release req_ready", 32'(req_ready[1]), 32'd1);

        // ---- accept spacing for WAIT_CYCLES 0 and 3 ----
        for (int d = 0; d < ND; d += 2) begin
            do_txn(d, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, acc);
            do_txn(d, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat, acc2);
            check($sformatf("d%0d accept spacing", d), acc2 - acc, wc(d) + 2);
        end

        // ---- reset during WAIT of a write (WAIT_CYCLES=3) ----
        txn_check(2, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        @(negedge clk);
        req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h5566_7788;
        req_wstrb[2] = 4'hF; req_valid[2] = 1'b1;
        bad = 0;
        while (!req_ready[2] && bad < TMO) begin @(negedge clk); bad++; end
        @(negedge clk);
        req_valid[2] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid-reset req_ready", 32'(req_ready[2]), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid[2]) bad++;
        end
        check("no response after reset", bad, 0);
        check("req_ready after mid-reset", 32'(req_ready[2]), 32'd1);
        txn_check(2, 1'b0, 32'h20, 32'h0, 4'h0);

        // ---- randomized traffic against the model ----
        for (int d = 0; d < ND; d++) begin
            for (int w = 0; w < 16; w++)
                txn_check(d, 1'b1, 32'(w * 4), $urandom, 4'hF);
            for (int n = 0; n < 50; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 15) * 4);
                    7:                   a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                    8:                   a = 32'h800 + 32'($urandom_range(0, 15) * 4);
                    default:             a = $urandom | 32'h0000_0800;
                endcase
                txn_check(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's data load/store port: accepts one request at a time over a valid/ready channel and performs a word read or a byte-masked write on a 512 x 32 synchronous RAM. It returns the result on a separate valid/ready response channel after a programmable number of wait states. It sits between the CPU core (initiator) and data storage, replacing the core's direct `data_mem` array access.

## Interface
- `DATA_WIDTH`, 32: word width in bits; fixed at 32 (byte strobes assume 4 bytes).
- `WORDS`, 512: RAM depth in words; must be a power of two.
- `WAIT_CYCLES`, 1: extra wait states before the RAM access; legal range 0..15.
- `ADDR_WIDTH`, $clog2(WORDS): derived; word index width; not to be overridden.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE and not in reset.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte enables for writes; bit i enables byte [8i+7:8i]; ignored on reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready` (the accept edge), latch we/addr/wdata/wstrb.
  - If `WAIT_CYCLES`=0: perform the access at the accept edge and go to RESP.
  - Otherwise: load `wait_cnt` = `WAIT_CYCLES`-1 and go to WAIT.
- WAIT: decrement `wait_cnt`. When `wait_cnt`==0, perform the access on that edge and go to RESP.
- Access rules:
  - Word index is `addr[ADDR_WIDTH+1:2]`.
  - Error if `addr[1:0]`!=0, or if `addr[31:ADDR_WIDTH+2]`!=0. On error: no RAM write, `rsp_rdata`=0, `rsp_err`=1.
  - Read: `rsp_rdata` is the registered RAM output.
  - Write: update only the bytes enabled by `wstrb`. `wstrb`=0 is a legal no-op write with no error.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Only one request outstanding at a time. A new request is never accepted in the same cycle as a response handshake.
- Reset:
  - State IDLE; `req_ready`=0 during the reset cycle and 1 the cycle after.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `wait_cnt`=0.
  - RAM contents are not cleared.
- Reset mid-operation: the transaction is dropped and no response is produced. A write whose access edge has not yet occurred is not performed; a write already performed stays.

## Timing
- Accept at edge T. RAM access at edge T+`WAIT_CYCLES`. `rsp_valid` is high from the cycle after edge T+`WAIT_CYCLES`, i.e. `WAIT_CYCLES`+1 cycles after the accept edge.
- Minimum spacing between accepts is `WAIT_CYCLES`+2 cycles, when `rsp_ready` is held high.
- `req_ready` and `rsp_valid` are decoded from state registers only. No combinational path from any input to any output.
- Read-after-write to the same word in consecutive transactions returns the newly written data.
- A `req_valid` held high during WAIT or RESP is ignored; the initiator must keep it asserted until accepted.

## Structure
- Package `mem_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, RESP}
  - `DATA_BYTES`=4
  - `WAIT_CNT_WIDTH`=4
  - the misalign/range check as a function shared with the CPU-side requester
- Sub-module `mem_sram`: single-port synchronous RAM with registered read and per-byte write enables (`clk`, `we`, `be[3:0]`, `addr`, `wd`, `rd`). The responder holds only the FSM, the latches and the checks.

## Test plan
- Reset, then `WAIT_CYCLES`=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then read 0x10 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` two cycles after each accept.
- Byte strobes: after the above, write 0x10 with wdata 0x00000011, wstrb 0x1; read -> 0xDEADBE11.
- Errors: read 0x12 -> `rsp_err`=1, rdata 0. Write 0x800 (word 512) -> `rsp_err`=1; then read word 0 -> unchanged.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`, rdata and err stay stable and `req_ready` stays 0; on release -> IDLE the next cycle.
- `WAIT_CYCLES`=0 vs 3 with `rsp_ready`=1 and back-to-back requests -> accept spacing of 2 and 5 cycles respectively.
- Reset asserted during WAIT of a write to 0x20 (`WAIT_CYCLES`=3) -> no response; a read of 0x20 after reset returns its old value.
